// File: rtl/avmm_burst_read_master.sv
// ---------------------------------------------------------------------------
// avmm_burst_read_master
//
// Read-only Avalon-MM burst master. A one-cycle command (start address and
// beat count) is split into bursts of at most MAX_BURST beats. Each burst is
// issued on the Avalon read port, and its returned beats are streamed to the
// user side. Only one burst is outstanding at a time, so returned data never
// needs reordering or buffering beyond a single register stage.
//
// Typical use: weight/activation fetch for the NPU datapath through the HPS
// F2SDRAM port, or against an SDRAM BFM in simulation.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   read_start      one-cycle command pulse, accepted only when idle
//   read_addr       start byte address; low log2(bytes-per-beat) bits dropped
//   read_cnt        total beats to fetch (0 completes with no bus traffic)
//   read_valid      read_data carries a returned beat this cycle
//   read_data       returned beat, one cycle after the slave presents it
//   read_done       one-cycle pulse, the cycle after the final read_valid
//   read            Avalon read request
//   address         Avalon byte address of the current burst
//   burstcount      Avalon burst length of the current burst
//   waitrequest     Avalon slave stall
//   readdata        Avalon returned data
//   readdatavalid   Avalon returned data qualifier
// ---------------------------------------------------------------------------
module avmm_burst_read_master #(
  parameter int SDRAM_DATA_W = 128,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 11,
  parameter int MAX_BURST    = 16,
  parameter int BURST_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  // user command side
  input  logic                    read_start,
  input  logic [ADDR_W-1:0]       read_addr,
  input  logic [CNT_W-1:0]        read_cnt,
  output logic                    read_valid,
  output logic [SDRAM_DATA_W-1:0] read_data,
  output logic                    read_done,
  // Avalon-MM read master side
  output logic                    read,
  output logic [ADDR_W-1:0]       address,
  output logic [BURST_W-1:0]      burstcount,
  input  logic                    waitrequest,
  input  logic [SDRAM_DATA_W-1:0] readdata,
  input  logic                    readdatavalid
);

  localparam int BPB = SDRAM_DATA_W / 8;
  localparam int OFS = $clog2(BPB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [ADDR_W-1:0]   cur_addr;
  logic [CNT_W-1:0]    remaining;
  logic [BURST_W-1:0]  burst_len;
  logic [BURST_W-1:0]  beat_cnt;
  logic [BURST_W-1:0]  req_len;

  logic                start_ok;
  logic                accept;
  logic                beat_in;
  logic                last_beat;

  // Length of the next burst: whatever is left, capped at MAX_BURST.
  function automatic logic [BURST_W-1:0] clip_burst(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(MAX_BURST)) begin
      return BURST_W'(MAX_BURST);
    end
    return BURST_W'(rem);
  endfunction

  // Force the address onto a beat boundary.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(BPB - 1);
  endfunction

  // Byte distance covered by a burst of len beats; wraps with the address.
  function automatic logic [ADDR_W-1:0] burst_bytes(input logic [BURST_W-1:0] len);
    return ADDR_W'(len) << OFS;
  endfunction

  assign req_len  = clip_burst(remaining);

  // read_done is registered, so the controller is already back in IDLE while
  // the pulse is visible; a start coincident with that pulse is still refused.
  assign start_ok  = (state == IDLE) && read_start && !read_done;
  assign accept    = (state == REQ) && !waitrequest;
  assign beat_in   = (state == DATA) && readdatavalid;
  assign last_beat = beat_in && ((beat_cnt + BURST_W'(1)) == burst_len);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = (read_cnt == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (accept) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (last_beat) begin
          state_nxt = (remaining != '0) ? REQ : DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- Avalon request outputs ----
  // Everything here derives from registers that only move on acceptance, so
  // the request stays stable for as long as the slave stalls.
  always_comb begin
    read       = 1'b0;
    address    = '0;
    burstcount = '0;
    if (state == REQ) begin
      read       = 1'b1;
      address    = cur_addr;
      burstcount = req_len;
    end
  end

  // ---- command / burst bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
    end else begin
      if (start_ok) begin
        cur_addr  <= align_addr(read_addr);
        remaining <= read_cnt;
      end
      if (accept) begin
        burst_len <= req_len;
        beat_cnt  <= '0;
        remaining <= remaining - CNT_W'(req_len);
        cur_addr  <= cur_addr + burst_bytes(req_len);
      end else if (beat_in) begin
        beat_cnt  <= beat_cnt + BURST_W'(1);
      end
    end
  end

  // ---- return data stage: one register between slave and user ----
  // Gaps in readdatavalid pass straight through as gaps in read_valid. Data
  // arriving outside DATA (e.g. leftovers of a burst aborted by reset) is
  // dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_valid <= 1'b0;
      read_data  <= '0;
      read_done  <= 1'b0;
    end else begin
      read_valid <= beat_in;
      if (beat_in) begin
        read_data <= readdata;
      end
      read_done  <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_avmm_burst_read_master.sv
module tb_avmm_burst_read_master;

  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int CW  = 11;
  localparam int MB  = 16;
  localparam int BW  = 5;
  localparam int BPB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_start;
  logic [AW-1:0] read_addr;
  logic [CW-1:0] read_cnt;
  logic          read_valid;
  logic [DW-1:0] read_data;
  logic          read_done;
  logic          read;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  always #5 clk = ~clk;

  avmm_burst_read_master #(
    .SDRAM_DATA_W(DW),
    .ADDR_W      (AW),
    .CNT_W       (CW),
    .MAX_BURST   (MB),
    .BURST_W     (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_start   (read_start),
    .read_addr    (read_addr),
    .read_cnt     (read_cnt),
    .read_valid   (read_valid),
    .read_data    (read_data),
    .read_done    (read_done),
    .read         (read),
    .address      (address),
    .burstcount   (burstcount),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
  } req_t;

  req_t          rq[$];   // expected Avalon requests, in order
  logic [DW-1:0] dq[$];   // expected user beats, in order

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc = 0;
  int            beats_seen = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_rv_cyc = 0;
  int            rd_cycles = 0;
  int            pending = 0;
  int            stall_left = 0;
  bit            gap_mode = 1'b0;
  bit            drop_data = 1'b0;
  bit            exp_rv = 1'b0;
  logic [DW-1:0] next_val = '0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Slave model and output monitor, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;

      // user side: one read_valid per beat driven in the previous cycle
      check_eq("rv_timing", read_valid, exp_rv);
      if (read_valid === 1'b1) begin
        beats_seen++;
        last_rv_cyc = cyc;
        if (dq.size() == 0) check_eq("unexp_beat", read_valid, 0);
        else                check_eq("beat_data", read_data, dq.pop_front());
      end
      if (read_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end

      // slave data return for already accepted bursts
      exp_rv = 1'b0;
      if (pending > 0 && !(gap_mode && $urandom_range(0, 2) == 0)) begin
        readdatavalid = 1'b1;
        readdata      = next_val;
        pending--;
        if (!drop_data) begin
          dq.push_back(next_val);
          exp_rv = 1'b1;
        end
        next_val++;
      end else begin
        readdatavalid = 1'b0;
        readdata      = '0;
      end

      // slave request handling; the request is checked on every held cycle
      if (read === 1'b1) begin
        rd_cycles++;
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = 1'b0;
        end
        if (rq.size() == 0) begin
          check_eq("unexp_req", read, 0);
        end else begin
          check_eq("req_addr", address, rq[0].addr);
          check_eq("req_len", burstcount, rq[0].len);
          if (!waitrequest) begin
            pending += int'(burstcount);
            void'(rq.pop_front());
          end
        end
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] addr, input logic [CW-1:0] cnt);
    @(negedge clk); #1;
    read_start = 1'b1;
    read_addr  = addr;
    read_cnt   = cnt;
    @(negedge clk); #1;
    read_start = 1'b0;
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input int cnt, input int stall,
                         input bit gaps, input bit poke);
    logic [AW-1:0] a;
    int            rem;
    int            b;
    int            nreq;
    int            start_cyc;
    req_t          r;
    a    = addr & ~AW'(BPB - 1);
    rem  = cnt;
    nreq = 0;
    while (rem > 0) begin
      b = (rem > MB) ? MB : rem;
      r.addr = a;
      r.len  = b[BW-1:0];
      rq.push_back(r);
      a   = a + AW'(b * BPB);
      rem = rem - b;
      nreq++;
    end
    beats_seen = 0;
    done_cnt   = 0;
    rd_cycles  = 0;
    stall_left = stall;
    gap_mode   = gaps;
    next_val   = 1;

    @(negedge clk); #1;
    read_start = 1'b1;
    read_addr  = addr;
    read_cnt   = cnt[CW-1:0];
    start_cyc  = cyc;
    @(negedge clk); #1;
    read_start = 1'b0;

    if (poke) begin
      repeat (2) @(negedge clk);
      #1;
      pulse_start(32'h3000_0000, 11'd5);
    end

    for (int i = 0; i < cnt * 4 + 100 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == 0) check_eq("timeout", done_cnt, 1);
    repeat (4) @(negedge clk);
    #1;

    check_eq("done_cnt", done_cnt, 1);
    check_eq("beats", beats_seen, cnt);
    check_eq("req_left", rq.size(), 0);
    check_eq("data_left", dq.size(), 0);
    check_eq("rd_cycles", rd_cycles, nreq + stall);
    if (cnt == 0) check_eq("done_lat0", done_cyc - start_cyc, 2);
    else          check_eq("done_lat", done_cyc - last_rv_cyc, 1);
    gap_mode = 1'b0;
  endtask

  initial begin
    req_t r;
    rst           = 1'b1;
    read_start    = 1'b0;
    read_addr     = '0;
    read_cnt      = '0;
    waitrequest   = 1'b0;
    readdata      = '0;
    readdatavalid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_read", read, 0);
    check_eq("rst_rv", read_valid, 0);
    check_eq("rst_done", read_done, 0);
    check_eq("rst_addr", address, 0);
    check_eq("rst_bc", burstcount, 0);
    check_eq("rst_data", read_data, 0);
    rst = 1'b0;

    run_cmd(32'h2000_0000, 4, 0, 1'b0, 1'b0);      // single burst
    run_cmd(32'h2000_0000, 40, 0, 1'b0, 1'b0);     // 16 + 16 + 8
    run_cmd(32'h2000_0400, 4, 3, 1'b0, 1'b0);      // stalled request
    run_cmd(32'h2000_0000, 0, 0, 1'b0, 1'b0);      // empty command
    run_cmd(32'h2000_0007, 1, 0, 1'b0, 1'b0);      // unaligned start
    run_cmd(32'h2000_0800, 8, 0, 1'b0, 1'b1);      // start while busy
    run_cmd(32'h2000_1000, 37, 2, 1'b1, 1'b0);     // gaps in return data
    run_cmd(32'hFFFF_FF80, 20, 0, 1'b0, 1'b0);     // address wrap
    run_cmd(32'h0000_0000, 2047, 0, 1'b0, 1'b0);   // largest command

    // reset in the middle of a burst
    r.addr = 32'h2000_1000;
    r.len  = 5'd8;
    rq.push_back(r);
    beats_seen = 0;
    done_cnt   = 0;
    next_val   = 1;
    pulse_start(32'h2000_1000, 11'd8);
    for (int i = 0; i < 100 && beats_seen < 2; i++) begin
      @(negedge clk); #1;
    end
    check_eq("rst_mid_beats", beats_seen, 2);
    rst       = 1'b1;
    drop_data = 1'b1;
    exp_rv    = 1'b0;
    dq.delete();
    @(negedge clk); #1;
    check_eq("mid_read", read, 0);
    check_eq("mid_rv", read_valid, 0);
    check_eq("mid_done", read_done, 0);
    check_eq("mid_addr", address, 0);
    check_eq("mid_bc", burstcount, 0);
    check_eq("mid_data", read_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 40 && pending > 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (4) @(negedge clk);
    #1;
    drop_data = 1'b0;
    check_eq("mid_no_done", done_cnt, 0);
    check_eq("mid_req_left", rq.size(), 0);
    check_eq("mid_idle_read", read, 0);
    run_cmd(32'h2000_2000, 2, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avmm_burst_read_master.md
Name: avmm_burst_read_master

Overview:
- Read-only Avalon-MM burst master that turns a simple start/address/count command into one or more Avalon burst reads against SDRAM (HPS F2SDRAM port or an SDRAM BFM).
- Streams returned beats to the user side and signals completion.
- Sits between NPU datapath logic (weight/activation fetch) and the SDRAM read port.

Parameters:
- SDRAM_DATA_W, 128, data beat width in bits; bytes per beat BPB = SDRAM_DATA_W/8.
- ADDR_W, 32, byte-address width.
- CNT_W, 11, width of beat-count command.
- MAX_BURST, 16, maximum beats per Avalon burst (power of two).
- BURST_W, 5, burstcount width; must hold MAX_BURST.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- read_start  in  1  one-cycle command pulse.
- read_addr  in  ADDR_W  start byte address; sampled on read_start.
- read_cnt  in  CNT_W  total beats to read; sampled on read_start.
- read_valid  out  1  read_data holds a valid beat this cycle.
- read_data  out  SDRAM_DATA_W  returned beat.
- read_done  out  1  one-cycle pulse when the command completes.
- read  out  1  Avalon read request.
- address  out  ADDR_W  Avalon byte address.
- burstcount  out  BURST_W  Avalon burst length.
- waitrequest  in  1  slave stall.
- readdata  in  SDRAM_DATA_W  slave data.
- readdatavalid  in  1  slave data valid.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - read, read_valid and read_done = 0.
  - address, burstcount and read_data = 0.
  - Internal counters cleared.
- Reset mid-operation aborts the command: no read_done; subsequent stray readdatavalid is ignored.
- Command capture:
  - read_start in IDLE latches read_addr with its low log2(BPB) bits forced to 0, and latches read_cnt as remaining beats.
  - read_start outside IDLE is ignored.
- States:
  - IDLE:
    - read_start with cnt>0 -> REQ.
    - read_start with cnt=0 -> DONE.
  - REQ:
    - read=1, address=current address, burstcount=min(remaining, MAX_BURST).
    - Hold all three stable while waitrequest=1.
    - On a cycle with read=1 and waitrequest=0, the request is accepted -> DATA.
    - Also on acceptance: record burst length, subtract it from remaining, advance address by len*BPB.
    - read drops the cycle after acceptance.
  - DATA:
    - Count readdatavalid beats.
    - When the beat count equals the burst length: remaining>0 -> REQ (next cycle), else -> DONE.
    - Only one burst is outstanding at a time.
  - DONE: read_done=1 for exactly one cycle -> IDLE.
- Data path:
  - In DATA, each readdatavalid is registered and presented as read_valid=1 with read_data=readdata one cycle later, in arrival order.
  - Any gap in readdatavalid produces a matching gap in read_valid.
  - readdatavalid outside DATA is ignored.
- Timing:
  - read_done asserts in the cycle after the final read_valid.
  - For cnt=0, read_done asserts 2 cycles after read_start with no Avalon traffic.
- Arithmetic:
  - Address wraps modulo 2^ADDR_W.
  - remaining is CNT_W bits; the largest command is 2^CNT_W-1 beats.
- Simultaneous events: read_start in the same cycle as read_done is ignored; a new command is accepted only once back in IDLE.

Test Plan:
- Single burst: read_start, addr=0x2000_0000, cnt=4, waitrequest=0, slave returns 0x1..0x4 -> exactly one request with address=0x2000_0000, burstcount=4; read_valid beats 0x1,0x2,0x3,0x4 in order; read_done one cycle after the 4th.
- Burst splitting: cnt=40, addr=0x2000_0000 -> three requests: (0x2000_0000, 16), (0x2000_0100, 16), (0x2000_0200, 8); 40 read_valid beats; single read_done.
- Stall: waitrequest=1 for 3 cycles on the first request -> read/address/burstcount constant for 4 cycles, accepted on the 4th, no duplicate request.
- Zero/unaligned: cnt=0 -> no read, read_done 2 cycles after start. addr=0x2000_0007, cnt=1 -> address=0x2000_0000.
- Busy and gaps: second read_start during DATA ignored; gaps in readdatavalid give the same gaps in read_valid with an unchanged beat total.
- Reset mid-burst: rst=1 during DATA with 2 of 8 beats received -> outputs 0, IDLE, no read_done; a new cnt=2 command then completes normally.
